// File: rtl/hazard_unit.sv
// Hazard resolution for the 5-stage ARM pipeline: operand forwarding, load-use and
// branch stall/flush control, a multi-cycle MUL/MLA execute stall, and debug counters.
module hazard_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcW,
  input  logic             PCWrPendingF,
  input  logic             BranchTakenD,
  input  logic             MulOpE,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // First BUSY cycle already follows one stalled IDLE cycle, hence the -2.
  localparam logic [3:0] CNT_INIT = 4'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mul_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             mul_stall;
  logic             ldr_stall;

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
  end

  assign ldr_stall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MulOpE && (MUL_CYCLES > 1)) begin
          mul_stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          mul_stall = 1'b1;
          cnt_d     = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // While reset is held the multiply is abandoned, so no stall may leak out.
    if (!reset) mul_stall = 1'b0;
  end

  assign StallF  = ldr_stall | PCWrPendingF | mul_stall;
  assign StallD  = ldr_stall | mul_stall;
  assign StallE  = mul_stall;
  assign FlushM  = mul_stall;
  // An in-flight multiply is never squashed; a held branch re-resolves after release.
  assign FlushD  = (PCWrPendingF | PCSrcW | BranchTakenD) & ~mul_stall;
  assign FlushE  = (ldr_stall | BranchTakenD) & ~mul_stall;
  assign MulBusy = (state_q == BUSY);

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (CntClr) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (StallF && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + CNT_W'(1);
      if (FlushE && (flush_count_q != CNT_MAX)) flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard resolution stage for the 5-stage ARM core; consumes the controller's per-stage control outputs plus datapath register addresses.
- Produces operand-forwarding selects, per-stage stall/flush controls, and a multi-cycle execute stall for MUL/MLA.
- Maintains saturating stall/flush event counters for performance debug.

Parameters:
MUL_CYCLES, 4, execute-stage occupancy of MUL/MLA in cycles (legal range 1..15; 1 = no multiply stall)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
RA1D, RA2D  in  4  source register numbers in Decode
RA1E, RA2E  in  4  source register numbers in Execute
WA3E, WA3M, WA3W  in  4  destination register numbers in E/M/W
RegWriteM, RegWriteW  in  1  gated register-write enables from the controller
MemtoRegE  in  1  Execute instruction is a load
PCSrcW  in  1  PC write retiring in Writeback
PCWrPendingF  in  1  PC write pending in D, E or M
BranchTakenD  in  1  early-resolved taken branch in Decode
MulOpE  in  1  Execute instruction is MUL/MLA
CntClr  in  1  synchronous clear of both performance counters
ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM
StallF, StallD, StallE  out  1  hold the F, D and E pipeline registers
FlushD, FlushE, FlushM  out  1  clear the D/E/M pipeline registers to a bubble
MulBusy  out  1  multiply FSM in BUSY state
StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- Forwarding is combinational and checked per source: if RegWriteM and RA1E==WA3M, select 10; else if RegWriteW and RA1E==WA3W, select 01; else 00. Memory stage has priority. ForwardBE applies the same rule to RA2E.
- Load-use hazard: LDRstall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- Multiply FSM has states IDLE and BUSY, with a 4-bit down-counter cnt.
  - IDLE, MulOpE=1, MUL_CYCLES>1: MulStall=1 this cycle; next state BUSY with cnt=MUL_CYCLES-2.
  - BUSY, cnt!=0: MulStall=1 and cnt decrements.
  - BUSY, cnt==0: MulStall=0 (final E cycle); next state IDLE.
  - MUL_CYCLES=1: the FSM never leaves IDLE.
  - A multiply occupies E for exactly MUL_CYCLES cycles and adds MUL_CYCLES-1 stall cycles.
  - Back-to-back multiplies re-trigger from IDLE on the cycle after the previous one completes.
- MulBusy = (state==BUSY).
- Stall/flush equations, all combinational from current inputs and state:
  - StallF = LDRstall | PCWrPendingF | MulStall
  - StallD = LDRstall | MulStall
  - StallE = MulStall
  - FlushM = MulStall (a bubble enters M while the multiply iterates)
  - FlushD = (PCWrPendingF | PCSrcW | BranchTakenD) & ~MulStall
  - FlushE = (LDRstall | BranchTakenD) & ~MulStall
- MulStall masks flushes so an in-flight multiply is never squashed. A taken branch held in D is re-evaluated after the stall releases.
- PCSrcW and MulStall cannot coincide in legal instruction flow. If they do, FlushD stays masked.
- Counters:
  - StallCount increments on each cycle with StallF=1.
  - FlushCount increments on each cycle with FlushE=1.
  - Both saturate at all-ones.
  - CntClr=1 forces both to 0 on the next edge, overriding any increment.
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, StallCount=FlushCount=0, MulBusy=0.
  - Combinational outputs follow their equations with MulStall=0.
  - Reset mid-multiply abandons the operation; after release the FSM restarts only if MulOpE=1.
- No X propagation: with all enables 0, ForwardAE/BE=00 and all stall/flush outputs are 0.

Test Plan:
- Forward priority: WA3M=WA3W=3, RegWriteM=RegWriteW=1, RA1E=3 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then RegWriteW=0 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0, ForwardBE=00; StallCount and FlushCount each +1.
- Multiply, MUL_CYCLES=4: MulOpE held high -> MulStall/StallE/FlushM=1 for 3 cycles, MulBusy=1 on cycles 2-4, released on cycle 4. A second back-to-back multiply repeats the pattern. A BranchTakenD=1 pulse during the stall -> FlushE stays 0.
- Branch: BranchTakenD=1 with no other hazard -> FlushD=FlushE=1, StallF=0. PCWrPendingF=1 for 3 cycles -> StallF=FlushD=1 each cycle, StallCount+=3.
- Reset and saturation, CNT_W=4: hold StallF for 20 cycles -> StallCount=15. Pull reset low mid-multiply -> MulBusy=0 and counters 0 immediately (asynchronous). CntClr=1 together with an increment -> counter reads 0.
